binary_to_bcd: RTL and testbench



---
 rtl/binary_to_bcd_if.sv | 15 +
 rtl/binary_to_bcd.sv | 65 ++++++
 tb/tb_binary_to_bcd.sv | 131 +++++++++++++
 3 files changed

// File: rtl/binary_to_bcd_if.sv
// binary_to_bcd_if
//   Carries the binary count into the converter and the packed BCD result out
//   to the digit multiplexer.
//   bitcode : unsigned binary value (BIN_W bits), driven by the master
//   bcdcode : packed BCD, 4 bits per digit, ones digit in [3:0], driven by the slave
interface binary_to_bcd_if #(
   parameter int BIN_W  = 10,
   parameter int DIGITS = 4
) ();
   logic [BIN_W-1:0]    bitcode;
   logic [4*DIGITS-1:0] bcdcode;

   modport master (output bitcode, input  bcdcode);
   modport slave  (input  bitcode, output bcdcode);
endinterface

// File: rtl/binary_to_bcd.sv
// binary_to_bcd
//   Converts an unsigned binary count (reaction time in ms) into packed BCD
//   digits for the 7-segment display path. The double-dabble conversion is
//   fully combinational; the result is registered once (1-cycle latency, one
//   new input per cycle, no enable).
//   Ports:
//      clk    : system clock, rising edge
//      rst_n  : asynchronous active-low reset, clears bcdcode
//      bus    : binary_to_bcd_if.slave (bitcode in, bcdcode out)
module binary_to_bcd #(
   parameter int BIN_W  = 10,
   parameter int DIGITS = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   binary_to_bcd_if.slave   bus
);

   localparam int BCD_W = 4 * DIGITS;

   function automatic longint unsigned pow10(input int n);
      longint unsigned p;
      p = 64'd1;
      for (int k = 0; k < n; k++) begin
         p = p * 64'd10;
      end
      return p;
   endfunction

   localparam longint unsigned MAX_IN = (64'd1 << BIN_W) - 64'd1;

   // Every representable input must fit in the digit count; otherwise the
   // top bits would silently fall off the shift chain.
   if (pow10(DIGITS) <= MAX_IN) begin : g_range_err
      $error("binary_to_bcd: DIGITS too small for BIN_W");
   end

   logic [BCD_W-1:0] w_bcd;
   logic [BCD_W-1:0] r_bcdcode;

   // Shift-and-add-3: correct every digit >= 5 before each shift, MSB first.
   // Digits beyond the range never receive a bit, so they stay zero.
   always_comb begin
      w_bcd = '0;
      for (int i = BIN_W - 1; i >= 0; i--) begin
         for (int d = 0; d < DIGITS; d++) begin
            if (w_bcd[d*4 +: 4] >= 4'd5) begin
               w_bcd[d*4 +: 4] = w_bcd[d*4 +: 4] + 4'd3;
            end
         end
         w_bcd = {w_bcd[BCD_W-2:0], bus.bitcode[i]};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_bcdcode <= '0;
      end else begin
         r_bcdcode <= w_bcd;
      end
   end

   assign bus.bcdcode = r_bcdcode;

endmodule

// File: tb/tb_binary_to_bcd.sv
module tb_binary_to_bcd;

   localparam int BIN_W  = 10;
   localparam int DIGITS = 4;

   logic clk;
   logic rst_n;

   binary_to_bcd_if #(.BIN_W(BIN_W), .DIGITS(DIGITS)) u_if ();

   binary_to_bcd #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (u_if.slave)
   );

   initial clk = 1'b0;
   always #50 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;

   typedef struct {
      logic [9:0]  bin;
      logic [15:0] exp;
   } vec_t;

   vec_t vecs [9];

   // Reference model: decimal digits from plain division.
   function automatic logic [15:0] ref_bcd(input int v);
      logic [15:0] r;
      r[15:12] = 4'((v / 1000) % 10);
      r[11:8]  = 4'((v / 100) % 10);
      r[7:4]   = 4'((v / 10) % 10);
      r[3:0]   = 4'(v % 10);
      return r;
   endfunction

   function automatic bit digits_ok(input logic [15:0] b);
      bit ok;
      ok = 1'b1;
      for (int d = 0; d < 4; d++) begin
         if (b[d*4 +: 4] > 4'd9) ok = 1'b0;
      end
      return ok;
   endfunction

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   task automatic check_digits(input string name, input logic [15:0] act);
      n_total++;
      if (digits_ok(act)) n_pass++;
      else $display("FAIL %s: non-decimal digit in %h at %0t", name, act, $time);
   endtask

   initial begin
      vecs[0] = '{10'd0,    16'h0000};
      vecs[1] = '{10'd9,    16'h0009};
      vecs[2] = '{10'd10,   16'h0010};
      vecs[3] = '{10'd99,   16'h0099};
      vecs[4] = '{10'd100,  16'h0100};
      vecs[5] = '{10'd999,  16'h0999};
      vecs[6] = '{10'd1000, 16'h1000};
      vecs[7] = '{10'd1023, 16'h1023};
      vecs[8] = '{10'd0,    16'h0000};

      // Reset held with a nonzero input; output must be zero before any edge.
      rst_n = 1'b0;
      u_if.bitcode = 10'd555;
      #1;
      check("reset_immediate", u_if.bcdcode, 16'h0000);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("reset_hold", u_if.bcdcode, 16'h0000);
      end
      rst_n = 1'b1;
      #1;
      check("release_no_edge", u_if.bcdcode, 16'h0000);
      @(negedge clk);
      check("release_first_edge", u_if.bcdcode, 16'h0555);

      // Directed table: boundaries, rollovers, max then wrap.
      for (int i = 0; i < 9; i++) begin
         u_if.bitcode = vecs[i].bin;
         @(negedge clk);
         check($sformatf("vec_%0d", vecs[i].bin), u_if.bcdcode, vecs[i].exp);
      end

      // Exhaustive sweep with an asynchronous reset pulse at 512.
      for (int i = 0; i < 1024; i++) begin
         u_if.bitcode = 10'(i);
         @(posedge clk);
         if (i == 512) begin
            #20;
            rst_n = 1'b0;
            #1;
            check("sweep_async_reset", u_if.bcdcode, 16'h0000);
            @(negedge clk);
            check("sweep_reset_hold", u_if.bcdcode, 16'h0000);
            rst_n = 1'b1;
         end else begin
            @(negedge clk);
            check($sformatf("sweep_%0d", i), u_if.bcdcode, ref_bcd(i));
            check_digits("sweep_digits", u_if.bcdcode);
         end
      end
      // Tracking after the reset pulse, including the value held through it.
      u_if.bitcode = 10'd512;
      @(negedge clk);
      check("post_reset_512", u_if.bcdcode, 16'h0512);

      // Random back-to-back inputs against the reference model.
      for (int i = 0; i < 300; i++) begin
         int v;
         v = int'($urandom_range(0, 1023));
         u_if.bitcode = 10'(v);
         @(negedge clk);
         check($sformatf("rand_%0d", v), u_if.bcdcode, ref_bcd(v));
         check_digits("rand_digits", u_if.bcdcode);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
